ofm_writer: RTL and testbench



---
 rtl/ofm_writer.sv | 202 ++++++++++++++++++++
 tb/tb_ofm_writer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writer.sv
// ofm_writer: converts the conv_blk result stream into output-feature-map BRAM writes.
// Define OFM_WRITER_MAXPOOL_EN to insert 2x2 / stride-2 signed max pooling before the write.
module ofm_writer #(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 6,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int DATA_WIDTH  = 48,
    localparam int OUT_SIZE   = ((FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE) + 1,
    localparam int POOL_SIZE  = OUT_SIZE / 2,
    localparam int ADDR_WIDTH = $clog2(OUT_SIZE ** 2)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_go,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic                         o_wr_en,
    output logic        [ADDR_WIDTH-1:0] o_w_addr,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int NUM_SAMPLES = OUT_SIZE * OUT_SIZE;
    localparam int CNT_W       = $clog2(NUM_SAMPLES + 1);
    localparam int RC_W        = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic        [CNT_W-1:0]      cnt_q, cnt_d;
    logic        [RC_W-1:0]       row_q, row_d, col_q, col_d;
    logic        [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                         wr_en_q, wr_en_d;
    logic        [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic arm;
    logic accept;
    logic last_sample;

    assign arm         = i_go && (state_q == S_IDLE);
    assign accept      = i_en && (state_q == S_COLLECT);
    assign last_sample = (cnt_q == CNT_W'(NUM_SAMPLES - 1));

`ifdef OFM_WRITER_MAXPOOL_EN
    localparam int POOL_DEPTH = (POOL_SIZE > 0) ? POOL_SIZE : 1;
    localparam int PIDX_W     = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1;

    logic signed [DATA_WIDTH-1:0] h_q, h_d;
    logic signed [DATA_WIDTH-1:0] rowbuf_q [POOL_DEPTH];
    logic signed [DATA_WIDTH-1:0] rowbuf_d [POOL_DEPTH];
    logic        [PIDX_W-1:0]     pidx;
    logic signed [DATA_WIDTH-1:0] m_pair, m_quad;
    logic                         pool_wr;

    // Pooling datapath: strict '>' keeps the earlier value on ties.
    always_comb begin
        h_d      = h_q;
        rowbuf_d = rowbuf_q;
        pool_wr  = 1'b0;
        pidx     = PIDX_W'(col_q >> 1);
        m_pair   = (i_data > h_q) ? i_data : h_q;
        m_quad   = (m_pair > rowbuf_q[pidx]) ? m_pair : rowbuf_q[pidx];
        if (accept) begin
            if (!col_q[0]) begin
                h_d = i_data;
            end else if (!row_q[0]) begin
                rowbuf_d[pidx] = m_pair;
            end else begin
                pool_wr = 1'b1;
            end
        end else begin
            h_d = h_q;
        end
    end

    // Pooling registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            h_q <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < POOL_DEPTH; i++) begin
                rowbuf_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            h_q      <= h_d;
            rowbuf_q <= rowbuf_d;
        end
    end
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_go) state_d = S_COLLECT;
                else      state_d = S_IDLE;
            end
            S_COLLECT: begin
                if (i_en && last_sample) state_d = S_IDLE;
                else                     state_d = S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters and registered write-port outputs
    always_comb begin
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        addr_d   = addr_q;
        wr_en_d  = 1'b0;
        w_addr_d = w_addr_q;
        data_d   = data_q;
        done_d   = accept && last_sample;
        busy_d   = (state_d == S_COLLECT);
        err_d    = err_q | (i_en && (state_q == S_IDLE));
        if (arm) begin
            cnt_d  = {CNT_W{1'b0}};
            row_d  = {RC_W{1'b0}};
            col_d  = {RC_W{1'b0}};
            addr_d = {ADDR_WIDTH{1'b0}};
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (col_q == RC_W'(OUT_SIZE - 1)) begin
                col_d = {RC_W{1'b0}};
                row_d = row_q + RC_W'(1);
            end else begin
                col_d = col_q + RC_W'(1);
                row_d = row_q;
            end
`ifdef OFM_WRITER_MAXPOOL_EN
            if (pool_wr) begin
                wr_en_d  = 1'b1;
                w_addr_d = addr_q;
                data_d   = m_quad;
                addr_d   = addr_q + ADDR_WIDTH'(1);
            end else begin
                wr_en_d  = 1'b0;
            end
`else
            wr_en_d  = 1'b1;
            w_addr_d = addr_q;
            data_d   = i_data;
            addr_d   = addr_q + ADDR_WIDTH'(1);
`endif
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q    <= {CNT_W{1'b0}};
            row_q    <= {RC_W{1'b0}};
            col_q    <= {RC_W{1'b0}};
            addr_q   <= {ADDR_WIDTH{1'b0}};
            wr_en_q  <= 1'b0;
            w_addr_q <= {ADDR_WIDTH{1'b0}};
            data_q   <= {DATA_WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            w_addr_q <= w_addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_wr_en  = wr_en_q;
    assign o_w_addr = w_addr_q;
    assign o_data   = data_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_ofm_writer.sv
// Self-checking bench for ofm_writer: random and directed frames against a frame-level model.
// The model follows OFM_WRITER_MAXPOOL_EN the same way the design does.
module tb_ofm_writer;

    localparam int KS = 3;
    localparam int FS = 6;
    localparam int PD = 0;
    localparam int ST = 1;
    localparam int DW = 48;
    localparam int OS = ((FS - KS + 2 * PD) / ST) + 1;
    localparam int NS = OS * OS;
    localparam int PS = OS / 2;
    localparam int AW = $clog2(NS);
`ifdef OFM_WRITER_MAXPOOL_EN
    localparam int NW = PS * PS;
`else
    localparam int NW = NS;
`endif
    localparam int DONE_WR = (NW > 0 && (OS % 2 == 0 || NW == NS)) ? 1 : 0;

    logic                 clk = 1'b0;
    logic                 rst, go, en;
    logic signed [DW-1:0] din;
    logic                 wr_en, busy, done, err;
    logic        [AW-1:0] w_addr;
    logic signed [DW-1:0] dout;

    ofm_writer #(.KERNEL_SIZE(KS), .FM_SIZE(FS), .PADDING(PD), .STRIDE(ST), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_en(en), .i_data(din),
        .o_wr_en(wr_en), .o_w_addr(w_addr), .o_data(dout),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    // Capture of observed write-port activity, sampled on the falling edge
    logic        [AW-1:0] cap_addr[$];
    logic signed [DW-1:0] cap_data[$];
    int                   cap_cyc[$];
    int done_cnt, done_wr_cnt, busy_cnt, busy_at_done;
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            cap_addr.push_back(w_addr);
            cap_data.push_back(dout);
            cap_cyc.push_back(pcyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (wr_en === 1'b1) done_wr_cnt++;
            if (busy === 1'b1) busy_at_done++;
        end
        if (busy === 1'b1) busy_cnt++;
    end

    logic signed [DW-1:0] stim[NS];
    int                   drv_cyc[$];
    int                   go_cyc;
    logic signed [DW-1:0] expq[$];
    int                   exp_cyc[$];

    task automatic clear_capture();
        @(posedge clk);
        #1;
        cap_addr.delete(); cap_data.delete(); cap_cyc.delete(); drv_cyc.delete();
        done_cnt = 0; done_wr_cnt = 0; busy_cnt = 0; busy_at_done = 0;
    endtask

    task automatic cycle(input logic g, input logic e, input logic signed [DW-1:0] d);
        @(negedge clk);
        go = g; en = e; din = d;
        if (e) drv_cyc.push_back(pcyc);
    endtask

    function automatic logic signed [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < NS; i++) begin
            case (mode)
                0:       stim[i] = DW'(i);
                1:       stim[i] = DW'(i - 16);
                2:       stim[i] = DW'($signed($urandom_range(0, 6)) - 3);
                default: stim[i] = rnd();
            endcase
        end
    endtask

    // Arms a frame, streams NS samples (optionally with idle gaps and ignored i_go), then settles
    task automatic run_frame(input bit gaps, input logic go_with_en);
        @(negedge clk);
        go = 1'b1; en = go_with_en; din = rnd(); go_cyc = pcyc;
        for (int i = 0; i < NS; i++) begin
            if (gaps && i > 0) cycle(1'($urandom_range(0, 1)), 1'b0, rnd());
            cycle(1'b0, 1'b1, stim[i]);
        end
        cycle(1'b0, 1'b0, rnd());
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: whole-frame raster view; pooled output is the max of each 2x2 block
    task automatic build_expected();
        expq.delete(); exp_cyc.delete();
`ifdef OFM_WRITER_MAXPOOL_EN
        for (int pr = 0; pr < PS; pr++) begin
            for (int pc = 0; pc < PS; pc++) begin
                logic signed [DW-1:0] best;
                best = stim[2 * pr * OS + 2 * pc];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (stim[(2 * pr + dr) * OS + 2 * pc + dc] > best)
                            best = stim[(2 * pr + dr) * OS + 2 * pc + dc];
                expq.push_back(best);
                exp_cyc.push_back(drv_cyc[(2 * pr + 1) * OS + 2 * pc + 1] + 1);
            end
        end
`else
        for (int i = 0; i < NS; i++) begin
            expq.push_back(stim[i]);
            exp_cyc.push_back(drv_cyc[i] + 1);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd());
        cycle(1'b0, 1'b0, {DW{1'b0}});
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_total++;
            if ({wr_en, w_addr, dout, busy, done, err} !== {(AW + DW + 4){1'b0}})
                $display("FAIL reset_idle[%0d]: wr=%b addr=%0d data=%0d busy=%b done=%b err=%b, expected all 0",
                         i, wr_en, w_addr, dout, busy, done, err);
            else n_pass++;
        end
    endtask

    task automatic test_passthrough();
        for (int mode = 0; mode < 5; mode++) begin
            clear_capture();
            fill(mode);
            run_frame(1'b0, 1'b0);
            build_expected();
            n_total++;
            if (cap_data.size() != NW) $display("FAIL frame%0d_count: got %0d writes, expected %0d", mode, cap_data.size(), NW);
            else n_pass++;
            for (int k = 0; k < NW; k++) begin
                n_total++;
                if (k >= cap_data.size() || cap_addr[k] !== AW'(k) || cap_data[k] !== expq[k] || cap_cyc[k] != exp_cyc[k])
                    $display("FAIL frame%0d_write[%0d]: addr %0d data %0d cyc %0d, expected addr %0d data %0d cyc %0d",
                             mode, k, cap_addr[k], cap_data[k], cap_cyc[k], k, expq[k], exp_cyc[k]);
                else n_pass++;
            end
            n_total++;
            if (done_cnt != 1 || done_wr_cnt != DONE_WR)
                $display("FAIL frame%0d_done: pulses %0d with_write %0d, expected 1 and %0d", mode, done_cnt, done_wr_cnt, DONE_WR);
            else n_pass++;
            n_total++;
            if (busy_cnt != drv_cyc[NS - 1] - go_cyc || busy_at_done != 0)
                $display("FAIL frame%0d_busy: cycles %0d high_at_done %0d, expected %0d and 0",
                         mode, busy_cnt, busy_at_done, drv_cyc[NS - 1] - go_cyc);
            else n_pass++;
            n_total++;
            if (wr_en !== 1'b0 || w_addr !== AW'(NW - 1) || dout !== expq[NW - 1])
                $display("FAIL frame%0d_hold: wr %b addr %0d data %0d, expected 0 %0d %0d", mode, wr_en, w_addr, dout, NW - 1, expq[NW - 1]);
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        for (int mode = 0; mode < 4; mode += 3) begin
            clear_capture();
            fill(mode);
            run_frame(1'b1, 1'b0);
            build_expected();
            n_total++;
            if (cap_data.size() != NW || done_cnt != 1) $display("FAIL gaps%0d_count: writes %0d done %0d, expected %0d and 1", mode, cap_data.size(), done_cnt, NW);
            else n_pass++;
            for (int k = 0; k < NW; k++) begin
                n_total++;
                if (k >= cap_data.size() || cap_addr[k] !== AW'(k) || cap_data[k] !== expq[k] || cap_cyc[k] != exp_cyc[k])
                    $display("FAIL gaps%0d_write[%0d]: addr %0d data %0d cyc %0d, expected addr %0d data %0d cyc %0d",
                             mode, k, cap_addr[k], cap_data[k], cap_cyc[k], k, expq[k], exp_cyc[k]);
                else n_pass++;
            end
            n_total++;
            if (busy_cnt != drv_cyc[NS - 1] - go_cyc || busy_at_done != 0)
                $display("FAIL gaps%0d_busy: cycles %0d, expected %0d", mode, busy_cnt, drv_cyc[NS - 1] - go_cyc);
            else n_pass++;
        end
    endtask

    task automatic test_err();
        clear_capture();
        n_total++;
        if (err !== 1'b0) $display("FAIL err_before: got %b, expected 0", err);
        else n_pass++;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rnd());
        cycle(1'b0, 1'b0, rnd());
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (cap_data.size() != 0 || err !== 1'b1 || busy !== 1'b0)
            $display("FAIL err_idle_en: writes %0d err %b busy %b, expected 0 1 0", cap_data.size(), err, busy);
        else n_pass++;
        clear_capture();
        fill(3);
        run_frame(1'b0, 1'b0);
        build_expected();
        for (int k = 0; k < NW; k++) begin
            n_total++;
            if (k >= cap_data.size() || cap_addr[k] !== AW'(k) || cap_data[k] !== expq[k])
                $display("FAIL err_frame_write[%0d]: addr %0d data %0d, expected addr %0d data %0d", k, cap_addr[k], cap_data[k], k, expq[k]);
            else n_pass++;
        end
        n_total++;
        if (err !== 1'b1 || done_cnt != 1 || cap_data.size() != NW)
            $display("FAIL err_sticky: err %b done %0d writes %0d, expected 1 1 %0d", err, done_cnt, cap_data.size(), NW);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int first_done;
        clear_capture();
        fill(3);
        @(negedge clk);
        go = 1'b1; en = 1'b0;
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, stim[i]);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({wr_en, w_addr, dout, busy, done, err} !== {(AW + DW + 4){1'b0}})
            $display("FAIL midrst_clear: wr=%b addr=%0d data=%0d busy=%b done=%b err=%b, expected all 0", wr_en, w_addr, dout, busy, done, err);
        else n_pass++;
        rst = 1'b1;
        first_done = done_cnt;
        clear_capture();
        fill(3);
        run_frame(1'b0, 1'b0);
        build_expected();
        for (int k = 0; k < NW; k++) begin
            n_total++;
            if (k >= cap_data.size() || cap_addr[k] !== AW'(k) || cap_data[k] !== expq[k])
                $display("FAIL midrst_write[%0d]: addr %0d data %0d, expected addr %0d data %0d", k, cap_addr[k], cap_data[k], k, expq[k]);
            else n_pass++;
        end
        n_total++;
        if (first_done != 0 || done_cnt != 1 || cap_data.size() != NW)
            $display("FAIL midrst_done: aborted %0d second %0d writes %0d, expected 0 1 %0d", first_done, done_cnt, cap_data.size(), NW);
        else n_pass++;
    endtask

    task automatic test_go_en_same_cycle();
        clear_capture();
        fill(3);
        run_frame(1'b0, 1'b1);
        build_expected();
        for (int k = 0; k < NW; k++) begin
            n_total++;
            if (k >= cap_data.size() || cap_addr[k] !== AW'(k) || cap_data[k] !== expq[k])
                $display("FAIL goen_write[%0d]: addr %0d data %0d, expected addr %0d data %0d", k, cap_addr[k], cap_data[k], k, expq[k]);
            else n_pass++;
        end
        n_total++;
        if (err !== 1'b1 || done_cnt != 1 || cap_data.size() != NW)
            $display("FAIL goen_err: err %b done %0d writes %0d, expected 1 1 %0d", err, done_cnt, cap_data.size(), NW);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; en = 1'b0; din = {DW{1'b0}};
        test_reset();
        test_passthrough();
        test_gaps();
        test_err();
        test_reset_mid_frame();
        test_go_en_same_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
